fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the core; sits directly upstream of decode.
- Consumes the single-cycle fetch_enable pulse from the pipeline sequencer and reads one instruction word from instruction BRAM at the current PC.
- Returns a one-cycle fetch_done pulse to the sequencer and presents the instruction and its PC to decode.
- Owns the architectural PC: advances it by 4 on each fetch, or loads a redirect target from the write stage.

Parameters:
ADDR_WIDTH, 32, width of the PC and mem_addr (byte address)
MEM_LATENCY, 2, cycles from the mem_en cycle until mem_rdata is valid (legal range 1..7)
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous reset, active low
fetch_enable  in  1  one-cycle start pulse from the sequencer
flush  in  1  discard the in-flight fetch result (from the sequencer stall path)
pc_we  in  1  PC redirect strobe from the write stage
pc_next  in  ADDR_WIDTH  redirect target
mem_en  out  1  instruction BRAM read strobe
mem_addr  out  ADDR_WIDTH  BRAM byte address
mem_rdata  in  32  BRAM read data
instr  out  32  fetched instruction, held until the next capture
instr_pc  out  ADDR_WIDTH  PC of instr
instr_valid  out  1  instr is usable by decode (0 after a flushed fetch)
fetch_done  out  1  one-cycle completion pulse to the sequencer
busy  out  1  a fetch is in flight

Behaviour:
- Reset (async, rstn=0):
  - pc=RESET_PC, state=IDLE.
  - mem_en=0, mem_addr=RESET_PC, instr=0, instr_pc=RESET_PC.
  - instr_valid=0, fetch_done=0, busy=0.
- FSM states: IDLE, REQ, WAIT, CAPT.
- IDLE, fetch_enable=1 at edge: go to REQ.
  - mem_en<=1, mem_addr<=pc, busy<=1.
  - Latch pc into the request-PC register.
  - Clear the latency counter and the kill bit.
- REQ (one cycle, mem_en=1): at the edge, mem_en<=0.
  - If MEM_LATENCY==1, go to CAPT; otherwise go to WAIT.
- WAIT: counter increments each cycle; go to CAPT once MEM_LATENCY cycles have elapsed since REQ.
- CAPT edge (mem_rdata valid in this cycle):
  - instr<=mem_rdata, instr_pc<=request PC, instr_valid<=~kill.
  - fetch_done<=1 for exactly one cycle, busy<=0, go to IDLE.
- Latency: fetch_enable seen at cycle 0 -> mem_en high in cycle 1 -> rdata valid in cycle 1+MEM_LATENCY -> fetch_done/instr visible in cycle 2+MEM_LATENCY (cycle 4 at the default).
- fetch_done and all outputs are registered; no combinational path from any input to any output.
- PC update, evaluated every edge in any state:
  - pc_we=1: pc<=pc_next.
  - Otherwise, on the IDLE->REQ edge: pc<=pc+4.
  - pc_we wins over the increment when both occur on the same edge. The request in flight still uses the old pc; the next fetch uses pc_next.
  - pc+4 wraps modulo 2^ADDR_WIDTH; the low 2 bits of pc_next are forced to 0.
- fetch_enable while busy=1: ignored, no state change. The sequencer guarantees this does not occur; the bench checks it is harmless.
- flush:
  - While busy=1, or on the same edge as the start: sets kill. The fetch still completes and fetch_done still pulses, so the sequencer's done tracking never deadlocks, but instr_valid=0.
  - In IDLE: clears instr_valid immediately (next edge).
- flush and CAPT on the same edge: instr_valid<=0.
- Reset asserted mid-fetch: immediate return to reset values; no fetch_done is produced.

Test Plan:
- Reset then fetch_enable at cycle 0, MEM_LATENCY=2, mem_rdata=0x00A00093 at addr 0 -> mem_en=1 only in cycle 1 with mem_addr=0; fetch_done=1 only in cycle 4; instr=0x00A00093, instr_pc=0, instr_valid=1; next fetch uses mem_addr=4.
- Three back-to-back fetches (enable each cycle after fetch_done) -> mem_addr sequence 0, 4, 8; exactly three fetch_done pulses; busy low between them.
- pc_we=1 with pc_next=0x100 on the same edge as fetch_enable -> that fetch uses addr 0; the following fetch uses addr 0x100, not 4.
- flush during WAIT -> fetch_done still pulses at cycle 4, instr_valid=0; the next fetch returns instr_valid=1.
- pc=0xFFFFFFFC, fetch -> following mem_addr=0x00000000; pc_next=0x103 -> mem_addr=0x100.
- rstn low during WAIT -> all outputs at reset values asynchronously; no fetch_done; extra fetch_enable while busy -> exactly one mem_en and one fetch_done. Repeat the first scenario at MEM_LATENCY=1 -> fetch_done in cycle 3.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch, owns the PC and reads one BRAM word per fetch_enable pulse
module fetch_stage #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    MEM_LATENCY = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  fetch_enable,
    input  logic                  flush,
    input  logic                  pc_we,
    input  logic [ADDR_WIDTH-1:0] pc_next,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata,
    output logic [31:0]           instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    output logic                  fetch_done,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, CAPT} state_t;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_LATENCY - 2);

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic [2:0]            cnt;
    logic                  kill;

    // PC ownership plus the request/wait/capture sequence; every output is registered
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            req_pc      <= RESET_PC;
            cnt         <= '0;
            kill        <= 1'b0;
            mem_en      <= 1'b0;
            mem_addr    <= RESET_PC;
            instr       <= '0;
            instr_pc    <= RESET_PC;
            instr_valid <= 1'b0;
            fetch_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            fetch_done <= 1'b0;
            if (pc_we)
                pc <= pc_next & ~ADDR_WIDTH'(3);
            else if (state == IDLE && fetch_enable)
                pc <= pc + ADDR_WIDTH'(4);
            if (busy)
                kill <= kill | flush;
            case (state)
                IDLE: begin
                    if (flush)
                        instr_valid <= 1'b0;
                    if (fetch_enable) begin
                        state    <= REQ;
                        mem_en   <= 1'b1;
                        mem_addr <= pc;
                        req_pc   <= pc;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        kill     <= flush;
                    end
                end
                REQ: begin
                    mem_en <= 1'b0;
                    state  <= (MEM_LATENCY == 1) ? CAPT : WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == WAIT_LAST)
                        state <= CAPT;
                end
                CAPT: begin
                    instr       <= mem_rdata;
                    instr_pc    <= req_pc;
                    instr_valid <= ~(kill | flush);
                    fetch_done  <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage at MEM_LATENCY 2 and 1
module tb_fetch_stage;
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } exp_t;

    localparam logic [31:0] BAD = 32'hDEADBEEF;

    logic        clk, rstn, fetch_enable, flush, pc_we;
    logic [31:0] pc_next;
    logic        mem_en, instr_valid, fetch_done, busy;
    logic [31:0] mem_addr, mem_rdata, instr, instr_pc;
    logic        mem_en1, instr_valid1, fetch_done1, busy1;
    logic [31:0] mem_addr1, mem_rdata1, instr1, instr_pc1;
    logic [31:0] p0, p1, q0;
    logic [31:0] mpc;
    exp_t        sb[$];
    exp_t        sb1[$];
    exp_t        last;
    int          total = 0;
    int          bad = 0;

    fetch_stage #(.ADDR_WIDTH(32), .MEM_LATENCY(2), .RESET_PC(32'h0)) dut (
        .clk(clk), .rstn(rstn), .fetch_enable(fetch_enable), .flush(flush),
        .pc_we(pc_we), .pc_next(pc_next), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .fetch_done(fetch_done), .busy(busy));

    fetch_stage #(.ADDR_WIDTH(32), .MEM_LATENCY(1), .RESET_PC(32'h0)) dut1 (
        .clk(clk), .rstn(rstn), .fetch_enable(fetch_enable), .flush(flush),
        .pc_we(pc_we), .pc_next(pc_next), .mem_en(mem_en1), .mem_addr(mem_addr1),
        .mem_rdata(mem_rdata1), .instr(instr1), .instr_pc(instr_pc1),
        .instr_valid(instr_valid1), .fetch_done(fetch_done1), .busy(busy1));

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h00A00093;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM models: data valid exactly MEM_LATENCY cycles after the mem_en cycle, garbage otherwise
    always @(posedge clk) begin
        p0 <= mem_en ? mdata(mem_addr) : BAD;
        p1 <= p0;
        q0 <= mem_en1 ? mdata(mem_addr1) : BAD;
    end
    assign mem_rdata  = p1;
    assign mem_rdata1 = q0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".mem_en"}, 32'(mem_en), 0);
        chk({tag, ".mem_addr"}, mem_addr, 0);
        chk({tag, ".instr"}, instr, 0);
        chk({tag, ".instr_pc"}, instr_pc, 0);
        chk({tag, ".valid"}, 32'(instr_valid), 0);
        chk({tag, ".done"}, 32'(fetch_done), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".mem_en1"}, 32'(mem_en1), 0);
        chk({tag, ".busy1"}, 32'(busy1), 0);
        chk({tag, ".done1"}, 32'(fetch_done1), 0);
    endtask

    // One fetch: push expectation, check request cycle, then completion timing and data on both DUTs
    task automatic fetch(input string tag, input bit we, input logic [31:0] nxt, input bit fl, input bit dbl);
        exp_t e, g;
        logic [31:0] ea;
        int c;
        bit d0, d1;
        ea = mpc;
        e.instr = mdata(mpc);
        e.pc = mpc;
        e.valid = !fl;
        sb.push_back(e);
        sb1.push_back(e);
        mpc = we ? (nxt & ~32'd3) : mpc + 32'd4;
        fetch_enable = 1'b1;
        pc_we = we;
        pc_next = nxt;
        @(negedge clk);
        fetch_enable = 1'b0;
        pc_we = 1'b0;
        c = 1;
        chk({tag, ".req_en"}, 32'(mem_en), 1);
        chk({tag, ".req_addr"}, mem_addr, ea);
        chk({tag, ".req_busy"}, 32'(busy), 1);
        chk({tag, ".req_en1"}, 32'(mem_en1), 1);
        chk({tag, ".req_addr1"}, mem_addr1, ea);
        d0 = 0;
        d1 = 0;
        while (!d0 && c < 20) begin
            flush = (c == 2) ? fl : 1'b0;
            fetch_enable = (c == 2) ? dbl : 1'b0;
            @(negedge clk);
            c++;
            if (fetch_done1 && !d1) begin
                d1 = 1;
                g = sb1.pop_front();
                chk({tag, ".cyc1"}, 32'(c), 3);
                chk({tag, ".instr1"}, instr1, g.instr);
                chk({tag, ".pc1"}, instr_pc1, g.pc);
                chk({tag, ".valid1"}, 32'(instr_valid1), 32'(g.valid));
            end
            if (fetch_done) begin
                d0 = 1;
                g = sb.pop_front();
                last = g;
                chk({tag, ".cyc"}, 32'(c), 4);
                chk({tag, ".instr"}, instr, g.instr);
                chk({tag, ".pc"}, instr_pc, g.pc);
                chk({tag, ".valid"}, 32'(instr_valid), 32'(g.valid));
                chk({tag, ".busy_end"}, 32'(busy), 0);
            end else begin
                chk({tag, ".en_low"}, 32'(mem_en), 0);
            end
        end
        flush = 1'b0;
        fetch_enable = 1'b0;
        if (!d0) chk({tag, ".timeout"}, 0, 1);
        if (!d1) chk({tag, ".timeout1"}, 0, 1);
        @(negedge clk);
        chk({tag, ".pulse"}, 32'(fetch_done), 0);
        chk({tag, ".pulse1"}, 32'(fetch_done1), 0);
        chk({tag, ".idle"}, 32'(busy), 0);
        chk({tag, ".idle_en"}, 32'(mem_en), 0);
    endtask

    initial begin
        rstn = 1'b0;
        fetch_enable = 1'b0;
        flush = 1'b0;
        pc_we = 1'b0;
        pc_next = '0;
        mpc = '0;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rstn = 1'b1;
        @(negedge clk);
        fetch("first", 0, 0, 0, 0);
        fetch("b2b1", 0, 0, 0, 0);
        fetch("b2b2", 0, 0, 0, 0);
        fetch("redir", 1, 32'h100, 0, 0);
        fetch("after_redir", 0, 0, 0, 0);
        fetch("flush_wait", 0, 0, 1, 0);
        fetch("after_flush", 0, 0, 0, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("idle_flush.valid", 32'(instr_valid), 0);
        chk("idle_flush.instr", instr, last.instr);
        chk("idle_flush.busy", 32'(busy), 0);
        fetch("set_top", 1, 32'hFFFFFFFC, 0, 0);
        fetch("at_top", 0, 0, 0, 0);
        fetch("wrapped", 1, 32'h103, 0, 0);
        fetch("aligned", 0, 0, 0, 0);
        fetch("double_en", 0, 0, 0, 1);
        fetch("after_double", 0, 0, 0, 0);
        fetch_enable = 1'b1;
        @(negedge clk);
        fetch_enable = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b0;
        #1 chk_reset("async_rst");
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold.done", 32'(fetch_done), 0);
            chk("rst_hold.busy", 32'(busy), 0);
        end
        rstn = 1'b1;
        mpc = '0;
        @(negedge clk);
        chk("post_rst.done", 32'(fetch_done), 0);
        fetch("rerun", 0, 0, 0, 0);
        fetch("rerun_next", 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
